// File: rtl/hazard_forward_if.sv
// Datapath <-> hazard/forwarding unit bundle: D/E-stage fields in, mux selects,
// pipeline controls and performance counters out.
interface hazard_forward_if #(
  parameter int RegAddrW = 5,
  parameter int CntW     = 32
);
  logic [RegAddrW-1:0] rs1_d;
  logic [RegAddrW-1:0] rs2_d;
  logic [RegAddrW-1:0] rs1_e;
  logic [RegAddrW-1:0] rs2_e;
  logic [RegAddrW-1:0] rd_e;
  logic                reg_write_e;
  logic                is_load_e;
  logic                pc_src_e;
  logic [1:0]          forward_a_e;
  logic [1:0]          forward_b_e;
  logic                stall_f;
  logic                stall_d;
  logic                flush_d;
  logic                flush_e;
  logic [CntW-1:0]     lu_stall_cnt;
  logic [CntW-1:0]     flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, is_load_e, pc_src_e,
    input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
           lu_stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, is_load_e, pc_src_e,
    output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
           lu_stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding selects, load-use stall / control flush generation
// and saturating event counters for a 5-stage RISC-V pipeline.
module hazard_forward_unit #(
  parameter int RegAddrW = 5,
  parameter int CntW     = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_forward_if.slave  bus
);

  logic [RegAddrW-1:0] rd_m_q, rd_m_d;
  logic [RegAddrW-1:0] rd_w_q, rd_w_d;
  logic                reg_write_m_q, reg_write_m_d;
  logic                reg_write_w_q, reg_write_w_d;
  logic [CntW-1:0]     lu_cnt_q, lu_cnt_d;
  logic [CntW-1:0]     flush_cnt_q, flush_cnt_d;
  logic                lu;

  // Youngest producer wins: MEM is checked before WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [RegAddrW-1:0] rs,
    input logic [RegAddrW-1:0] rd_m, input logic we_m,
    input logic [RegAddrW-1:0] rd_w, input logic we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != '0) && (rd_m == rs))      sel = 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lu = bus.is_load_e && (bus.rd_e != '0) &&
         ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    bus.forward_a_e = '0;
    bus.forward_b_e = '0;
    bus.stall_f     = 1'b0;
    bus.stall_d     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.flush_e     = 1'b0;
    if (!rst) begin
      bus.forward_a_e = fwd_sel(bus.rs1_e, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
      bus.forward_b_e = fwd_sel(bus.rs2_e, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
      bus.stall_f     = lu;
      bus.stall_d     = lu;
      bus.flush_d     = bus.pc_src_e;
      bus.flush_e     = lu | bus.pc_src_e;
    end

    bus.lu_stall_cnt = lu_cnt_q;
    bus.flush_cnt    = flush_cnt_q;
  end

  always_comb begin
    rd_m_d        = bus.rd_e;
    reg_write_m_d = bus.reg_write_e;
    rd_w_d        = rd_m_q;
    reg_write_w_d = reg_write_m_q;

    lu_cnt_d = lu_cnt_q;
    if (lu && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 1'b1;

    flush_cnt_d = flush_cnt_q;
    if (bus.pc_src_e && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_m_q        <= '0;
      rd_w_q        <= '0;
      reg_write_m_q <= 1'b0;
      reg_write_w_q <= 1'b0;
      lu_cnt_q      <= '0;
      flush_cnt_q   <= '0;
    end else begin
      rd_m_q        <= rd_m_d;
      rd_w_q        <= rd_w_d;
      reg_write_m_q <= reg_write_m_d;
      reg_write_w_q <= reg_write_w_d;
      lu_cnt_q      <= lu_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized + directed bench for hazard_forward_unit against a history-queue model.
module tb_hazard_forward_unit;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_if #(.RegAddrW(RW), .CntW(CW)) bus ();
  hazard_forward_unit #(.RegAddrW(RW), .CntW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int rd; bit we; } wr_t;
  wr_t hist[$];  // hist[0] = instruction now in MEM, hist[1] = in WB
  int  lu_cnt, fl_cnt;
  int  c_rs1d, c_rs2d, c_rs1e, c_rs2e, c_rde;
  bit  c_we, c_ld, c_pc, c_rst;

  function automatic int exp_fwd(input int rs);
    for (int k = 0; k < hist.size() && k < 2; k++)
      if (hist[k].we && hist[k].rd != 0 && hist[k].rd == rs) return (k == 0) ? 2 : 1;
    return 0;
  endfunction

  task automatic drive(input int rs1d, rs2d, rs1e, rs2e, rde,
                       input bit we, ld, pc, r);
    c_rs1d = rs1d; c_rs2d = rs2d; c_rs1e = rs1e; c_rs2e = rs2e; c_rde = rde;
    c_we = we; c_ld = ld; c_pc = pc; c_rst = r;
    bus.rs1_d = RW'(rs1d); bus.rs2_d = RW'(rs2d);
    bus.rs1_e = RW'(rs1e); bus.rs2_e = RW'(rs2e); bus.rd_e = RW'(rde);
    bus.reg_write_e = we; bus.is_load_e = ld; bus.pc_src_e = pc; rst = r;
  endtask

  // Drive one cycle's inputs and check every output against the model.
  task automatic cycle(input int rs1d, rs2d, rs1e, rs2e, rde,
                       input bit we, ld, pc, r);
    bit lu;
    drive(rs1d, rs2d, rs1e, rs2e, rde, we, ld, pc, r);
    #3;
    lu = ld && rde != 0 && (rde == rs1d || rde == rs2d);
    chk("fwd_a",   bus.forward_a_e, r ? 0 : exp_fwd(rs1e));
    chk("fwd_b",   bus.forward_b_e, r ? 0 : exp_fwd(rs2e));
    chk("stall_f", bus.stall_f, !r && lu);
    chk("stall_d", bus.stall_d, !r && lu);
    chk("flush_d", bus.flush_d, !r && pc);
    chk("flush_e", bus.flush_e, !r && (lu || pc));
    chk("lu_cnt",  bus.lu_stall_cnt, lu_cnt);
    chk("fl_cnt",  bus.flush_cnt, fl_cnt);
  endtask

  task automatic tick();
    bit lu;
    wr_t w;
    lu = c_ld && c_rde != 0 && (c_rde == c_rs1d || c_rde == c_rs2d);
    if (c_rst) begin
      hist.delete();
      lu_cnt = 0;
      fl_cnt = 0;
    end else begin
      w.rd = c_rde; w.we = c_we;
      hist.push_front(w);
      while (hist.size() > 2) void'(hist.pop_back());
      if (lu && lu_cnt < CMAX) lu_cnt++;
      if (c_pc && fl_cnt < CMAX) fl_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    hist.delete(); lu_cnt = 0; fl_cnt = 0;

    // reset state
    cycle(3, 4, 5, 5, 0, 0, 0, 0, 1); tick();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_lu_cnt", bus.lu_stall_cnt, 0);
    tick();

    // EX->MEM forward
    cycle(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    cycle(0, 0, 5, 1, 0, 0, 0, 0, 0);
    chk("t1_fa", bus.forward_a_e, 2'b10);
    chk("t1_fb", bus.forward_b_e, 2'b00);
    tick();
    // WB forward, and MEM override with an intervening writer
    cycle(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    cycle(0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("t2_fb_wb", bus.forward_b_e, 2'b01);
    tick();
    cycle(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    cycle(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    cycle(0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("t2_fb_mem", bus.forward_b_e, 2'b10);
    tick();

    // load-use stall, bubble, then WB forward
    idle(2);
    cycle(0, 7, 0, 0, 7, 1, 1, 0, 0);
    chk("t3_stall", {bus.stall_f, bus.stall_d, bus.flush_e}, 3'b111);
    tick();
    cycle(0, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_one_cyc", bus.stall_f, 1'b0);
    chk("t3_cnt", bus.lu_stall_cnt, 1);
    tick();
    cycle(0, 0, 0, 7, 0, 0, 0, 0, 0);
    chk("t3_fb_wb", bus.forward_b_e, 2'b01);
    tick();

    // x0 never forwards or stalls
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("t4_x0", {bus.stall_f, bus.forward_a_e, bus.forward_b_e}, 5'b0);
      tick();
    end

    // simultaneous load-use and redirect
    cycle(9, 0, 0, 0, 9, 1, 1, 1, 0);
    chk("t5_ctl", {bus.flush_d, bus.flush_e, bus.stall_f}, 3'b111);
    tick();

    // saturation then reset mid-stall
    for (int i = 0; i < CMAX + 4; i++) begin
      cycle(3, 0, 0, 0, 3, 1, 1, 1, 0);
      tick();
    end
    cycle(3, 0, 0, 0, 3, 1, 1, 1, 0);
    chk("t6_sat_lu", bus.lu_stall_cnt, CMAX);
    chk("t6_sat_fl", bus.flush_cnt, CMAX);
    tick();
    cycle(3, 0, 3, 3, 3, 1, 1, 1, 1);
    chk("t6_rst_ctl", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e,
                       bus.forward_a_e, bus.forward_b_e}, 8'b0);
    tick();
    cycle(0, 0, 3, 3, 0, 0, 0, 0, 0);
    chk("t6_rst_cnt", {bus.lu_stall_cnt, bus.flush_cnt}, 8'b0);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 39) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
